// File: rtl/mux_arb_pipe.sv
// mux_arb_pipe: arbitrated N-to-1 val/rdy merge into a single-entry registered output buffer.
//   clk, reset (async, active-high); in_val/in_rdy/in_msg: NINPUTS input channels,
//   channel i message at in_msg[i*NBITS +: NBITS]; out_val/out_rdy/out_msg/out_sel: merged output.
//   MUX_ARB_PIPE_RR_EN defined: round-robin arbitration; undefined: fixed priority (lowest index).
module mux_arb_pipe #(
  parameter int NBITS = 4,
  parameter int NINPUTS = 5,
  parameter int SELBITS = $clog2(NINPUTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NINPUTS-1:0]       in_val,
  output logic [NINPUTS-1:0]       in_rdy,
  input  logic [NINPUTS*NBITS-1:0] in_msg,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [NBITS-1:0]         out_msg,
  output logic [SELBITS-1:0]       out_sel
);
  logic [SELBITS-1:0] ptr;
  logic [SELBITS-1:0] g;
  logic found;
  logic acc;
  logic xfer;
  // Search starts at ptr and wraps; the first valid channel found wins.
  always_comb begin
    g = '0;
    found = 1'b0;
    for (int k = 0; k < NINPUTS; k++) begin
      int idx;
      idx = int'(ptr) + k;
      idx = idx >= NINPUTS ? idx - NINPUTS : idx;
      if (!found && in_val[idx]) begin
        found = 1'b1;
        g = SELBITS'(idx);
      end
    end
  end
  assign acc = !out_val || out_rdy;
  assign xfer = found && acc && !reset;
  assign in_rdy = xfer ? NINPUTS'(1) << g : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_val <= 1'b0;
      out_msg <= '0;
      out_sel <= '0;
    end else if (xfer) begin
      out_val <= 1'b1;
      out_msg <= in_msg[int'(g)*NBITS +: NBITS];
      out_sel <= g;
    end else if (out_rdy) begin
      out_val <= 1'b0;
    end
`ifdef MUX_ARB_PIPE_RR_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= '0;
    else if (xfer) ptr <= int'(g) == NINPUTS-1 ? '0 : g + 1'b1;
`else
  assign ptr = '0;
`endif
endmodule

// File: tb/tb_mux_arb_pipe.sv
// tb_mux_arb_pipe: table-driven scoreboard bench for mux_arb_pipe (NBITS=4, NINPUTS=5).
module tb_mux_arb_pipe;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] in_val = '0;
  logic [4:0] in_rdy;
  logic [19:0] in_msg = '0;
  logic out_val;
  logic out_rdy = 1'b0;
  logic [3:0] out_msg;
  logic [2:0] out_sel;

  mux_arb_pipe dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_sel(out_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] v;
    logic [19:0] m;
    logic r;
    int g_rr;
    int g_fp;
  } vec_t;
  typedef struct {
    logic [3:0] msg;
    logic [2:0] sel;
  } exp_t;

  vec_t tv[20];
  exp_t sb[$];
  exp_t held;
  logic m_val = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One handshake cycle: drive at negedge, check in_rdy, then check the buffer after the edge.
  task automatic step(input logic [4:0] v, input logic [19:0] m, input logic r, input int g);
    logic [4:0] exp_rdy;
    logic x;
    exp_t e;
    @(negedge clk);
    in_val = v;
    in_msg = m;
    out_rdy = r;
    #1;
    x = (g >= 0) && (!m_val || r);
    exp_rdy = x ? 5'(1) << g : 5'b0;
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    if (x) begin
      e.msg = m[g*4 +: 4];
      e.sel = 3'(g);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    m_val = x ? 1'b1 : (r ? 1'b0 : m_val);
    chk("out_val", 32'(out_val), 32'(m_val));
    if (x) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got 0 entries required 1");
      end else begin
        held = sb.pop_front();
        chk("out_msg", 32'(out_msg), 32'(held.msg));
        chk("out_sel", 32'(out_sel), 32'(held.sel));
      end
    end else if (m_val) begin
      chk("held_msg", 32'(out_msg), 32'(held.msg));
      chk("held_sel", 32'(out_sel), 32'(held.sel));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{5'b11111, 20'h54321, 1'b1, 0, 0};
    tv[1]  = '{5'b11111, 20'h54321, 1'b1, 1, 0};
    tv[2]  = '{5'b11111, 20'h54321, 1'b1, 2, 0};
    tv[3]  = '{5'b11111, 20'h54321, 1'b1, 3, 0};
    tv[4]  = '{5'b11111, 20'h54321, 1'b1, 4, 0};
    tv[5]  = '{5'b11111, 20'h54321, 1'b1, 0, 0};
    tv[6]  = '{5'b10000, 20'h54321, 1'b1, 4, 4};
    tv[7]  = '{5'b10001, 20'h54321, 1'b1, 0, 0};
    tv[8]  = '{5'b00100, 20'h00300, 1'b1, 2, 2};
    tv[9]  = '{5'b00100, 20'h00700, 1'b1, 2, 2};
    tv[10] = '{5'b00100, 20'h00A00, 1'b1, 2, 2};
    tv[11] = '{5'b10000, 20'h54321, 1'b1, 4, 4};
    tv[12] = '{5'b00011, 20'h54321, 1'b0, 0, 0};
    tv[13] = '{5'b00011, 20'h54321, 1'b0, 0, 0};
    tv[14] = '{5'b00011, 20'h54321, 1'b0, 0, 0};
    tv[15] = '{5'b00011, 20'h54321, 1'b1, 0, 0};
    tv[16] = '{5'b00000, 20'h00000, 1'b1, -1, -1};
    tv[17] = '{5'b00010, 20'h54321, 1'b0, 1, 1};
    tv[18] = '{5'b00000, 20'h00000, 1'b0, -1, -1};
    tv[19] = '{5'b00000, 20'h00000, 1'b1, -1, -1};
    held = '{4'h0, 3'h0};
    // Asynchronous reset asserted between clock edges, with every channel requesting.
    in_val = 5'b11111;
    in_msg = 20'h54321;
    #2 reset = 1'b1;
    #1;
    chk("rst_out_val", 32'(out_val), 32'h0);
    chk("rst_out_msg", 32'(out_msg), 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'h0);
    chk("rst_in_rdy", 32'(in_rdy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    in_val = '0;
    reset = 1'b0;
    step(5'b00000, 20'h0, 1'b1, -1);
    chk("idle_out_msg", 32'(out_msg), 32'h0);
    chk("idle_out_sel", 32'(out_sel), 32'h0);
    for (int i = 0; i < 20; i++) begin
`ifdef MUX_ARB_PIPE_RR_EN
      step(tv[i].v, tv[i].m, tv[i].r, tv[i].g_rr);
`else
      step(tv[i].v, tv[i].m, tv[i].r, tv[i].g_fp);
`endif
    end
    // Reset while holding a stalled message; pointer must return to 0.
    step(5'b00010, 20'h00090, 1'b0, 1);
    @(negedge clk);
    in_val = 5'b00110;
    in_msg = 20'h00560;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_val", 32'(out_val), 32'h0);
    chk("mid_rst_in_rdy", 32'(in_rdy), 32'h0);
    chk("mid_rst_out_msg", 32'(out_msg), 32'h0);
    m_val = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(5'b00110, 20'h00560, 1'b1, 1);
    step(5'b00000, 20'h0, 1'b1, -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_arb_pipe.md
Name: mux_arb_pipe

Overview:
- Parametrised successor to the team's fixed 4-bit 5-to-1 combinational mux.
- Merges NINPUTS latency-insensitive val/rdy input streams into one output stream.
- Input selection is by an internal arbiter, not an external select, and the result is registered in a single-entry output buffer.
- Sits in front of shared single-port resources, such as a memory request port or a shared ALU, where several producers contend.

Parameters:
- NBITS, 4, message width per channel (>=1).
- NINPUTS, 5, number of input channels (>=2).
- SELBITS, $clog2(NINPUTS), width of the out_sel index. Derived; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  NINPUTS  per-channel valid; bit i belongs to channel i.
- in_rdy  output  NINPUTS  per-channel ready; at most one bit high per cycle.
- in_msg  input  NINPUTS*NBITS  flattened messages; channel i occupies bits [i*NBITS +: NBITS].
- out_val  output  1  output buffer holds a valid message.
- out_rdy  input  1  downstream can accept the message.
- out_msg  output  NBITS  buffered message.
- out_sel  output  SELBITS  index of the channel that supplied out_msg.

Behaviour:
- Reset (async, active-high): out_val=0, out_msg=0, out_sel=0, priority pointer ptr=0.
- in_rdy is combinational while reset is high and must be all-zero during reset.
- Buffer can accept ("acc") when !out_val || out_rdy, so full throughput is sustained: one message per cycle.
- Grant g: the first i with in_val[i]=1, searching i = ptr, ptr+1, ..., NINPUTS-1, 0, ..., ptr-1 (wrap-around).
  - If no in_val bit is set, there is no grant.
- in_rdy[g] = acc. All other in_rdy bits = 0.
- in_rdy may depend combinationally on in_val and out_rdy. Producers must not make in_val depend on in_rdy.
- Transfer at the clock edge when in_val[g] && in_rdy[g]:
  - out_msg <= in_msg[g]; out_sel <= g; out_val <= 1.
  - ptr <= g+1, or 0 if g = NINPUTS-1.
- No transfer and out_val && out_rdy: out_val <= 0; out_msg and out_sel hold their stale values.
- out_val && !out_rdy (stall): out_val, out_msg and out_sel hold stable. All in_rdy = 0. ptr holds.
- Simultaneous drain and fill (out_val && out_rdy && an input transfer): the new message replaces the old one with no bubble; out_val stays 1.
- Latency: exactly 1 cycle from input transfer to out_val.
- ptr changes only on a transfer.
- Reset asserted mid-stream drops the buffered message; no handshake completes during reset.
- in_msg of non-granted channels never affects any output.

Optional Feature:
- Macro: MUX_ARB_PIPE_RR_EN.
- Defined: round-robin arbitration exactly as described above, using ptr.
- Undefined: fixed priority. Grant is the lowest index i with in_val[i]=1; ptr is not implemented (tied to 0).
- All ports, latency and handshake rules are identical in both builds.

Test Plan:
- Reset then idle: assert reset mid-cycle (async) -> out_val=0, out_msg=0, out_sel=0, in_rdy=5'b00000 immediately; after release with in_val=0, outputs remain 0.
- Single channel stream: in_val=5'b00100, in_msg[2] = 4'h3, 4'h7, 4'hA on consecutive cycles, out_rdy=1 -> out_msg 3, 7, A with out_sel=2, one cycle later each, no bubbles.
- Contention, RR build: in_val=5'b11111 held, channel i msg=4'h(i+1), out_rdy=1 -> out_sel sequence 0,1,2,3,4,0 with out_msg 1,2,3,4,5,1. Fixed-priority build -> out_sel stays 0.
- Backpressure: out_val=1, out_msg=4'h5, out_rdy=0 for 3 cycles with in_val=5'b00011 -> in_rdy=0, out_msg stays 4'h5; out_rdy=1 -> next out_msg from the granted channel, no loss or duplication.
- Wrap-around, RR build: grant channel 4 (ptr becomes 0), then in_val=5'b10001 -> channel 0 is granted.
- Reset mid-stream: out_val=1 holding 4'h9, assert reset -> out_val=0 asynchronously, ptr=0; first post-reset grant with in_val=5'b00110 -> channel 1.
